// File: rtl/mem_access_unit_if.sv
// Data-bus interface between the memory access unit (master) and the memory/bus fabric (slave).
// One req/ack transaction moves one aligned word; rdata is valid alongside ack on loads.
interface mem_access_unit_if;
   logic        o_MemReq_1;
   logic        o_MemWe_1;
   logic [31:0] o_MemAddr_32;
   logic [3:0]  o_MemWstrb_4;
   logic [31:0] o_MemWdata_32;
   logic        i_MemAck_1;
   logic [31:0] i_MemRdata_32;

   modport master (
      output o_MemReq_1, o_MemWe_1, o_MemAddr_32, o_MemWstrb_4, o_MemWdata_32,
      input  i_MemAck_1, i_MemRdata_32
   );

   modport slave (
      input  o_MemReq_1, o_MemWe_1, o_MemAddr_32, o_MemWstrb_4, o_MemWdata_32,
      output i_MemAck_1, i_MemRdata_32
   );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: one req/ack bus transaction per access, store lane alignment,
// load extraction with sign/zero extension, pipeline stall, misalign and timeout reporting.
module mem_access_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_Valid_1,
   input  logic        i_Load_1,
   input  logic        i_Store_1,
   input  logic        i_LoadUnsigned_1,
   input  logic [1:0]  i_LoadStoreWidth_2,
   input  logic [31:0] i_Addr_32,
   input  logic [31:0] i_StoreData_32,
   output logic        o_Stall_1,
   output logic [31:0] o_LoadData_32,
   output logic        o_LoadDataValid_1,
   output logic        o_MisalignExc_1,
   output logic        o_BusErr_1,
   mem_access_unit_if.master bus
);
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {IDLE, REQ, DONE, FAULT} state_t;

   state_t            state_q, state_d;
   logic [31:0]       addr_q, addr_d;
   logic [1:0]        off_q, off_d;
   logic [1:0]        width_q, width_d;
   logic              uns_q, uns_d;
   logic              is_load_q, is_load_d;
   logic              we_q, we_d;
   logic [3:0]        wstrb_q, wstrb_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       load_data_q, load_data_d;
   logic              bus_err_q, bus_err_d;

   logic              acc;
   logic              misaligned;
   logic              stall;
   logic [3:0]        strb_new;
   logic [31:0]       wdata_new;
   logic [31:0]       rdata_shift;
   logic [31:0]       load_ext;
   logic [CNT_W-1:0]  cnt_inc;

   assign acc = i_Valid_1 & (i_Load_1 | i_Store_1);

   always_comb begin
      misaligned = 1'b0;
      case (i_LoadStoreWidth_2)
         2'b01:   misaligned = i_Addr_32[0];
         2'b10:   misaligned = |i_Addr_32[1:0];
         2'b11:   misaligned = 1'b1;
         default: misaligned = 1'b0;
      endcase
   end

   // Store lanes: replicate the low bytes so every enabled lane already holds the right data.
   always_comb begin
      strb_new  = 4'b1111;
      wdata_new = i_StoreData_32;
      case (i_LoadStoreWidth_2)
         2'b00: begin
            strb_new  = 4'b0001 << i_Addr_32[1:0];
            wdata_new = {4{i_StoreData_32[7:0]}};
         end
         2'b01: begin
            strb_new  = 4'b0011 << i_Addr_32[1:0];
            wdata_new = {2{i_StoreData_32[15:0]}};
         end
         default: begin
            strb_new  = 4'b1111;
            wdata_new = i_StoreData_32;
         end
      endcase
      if (i_Load_1) begin
         strb_new = 4'b0000;
      end
   end

   always_comb begin
      rdata_shift = bus.i_MemRdata_32 >> {off_q, 3'b000};
      load_ext    = bus.i_MemRdata_32;
      case (width_q)
         2'b00:   load_ext = uns_q ? {24'd0, rdata_shift[7:0]}
                                   : {{24{rdata_shift[7]}}, rdata_shift[7:0]};
         2'b01:   load_ext = uns_q ? {16'd0, rdata_shift[15:0]}
                                   : {{16{rdata_shift[15]}}, rdata_shift[15:0]};
         default: load_ext = bus.i_MemRdata_32;
      endcase
   end

   assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      off_d       = off_q;
      width_d     = width_q;
      uns_d       = uns_q;
      is_load_d   = is_load_q;
      we_d        = we_q;
      wstrb_d     = wstrb_q;
      wdata_d     = wdata_q;
      cnt_d       = cnt_q;
      load_data_d = load_data_q;
      bus_err_d   = 1'b0;
      stall       = 1'b0;
      case (state_q)
         IDLE: begin
            if (acc) begin
               stall = 1'b1;
               if (misaligned) begin
                  state_d = FAULT;
               end else begin
                  state_d   = REQ;
                  addr_d    = {i_Addr_32[31:2], 2'b00};
                  off_d     = i_Addr_32[1:0];
                  width_d   = i_LoadStoreWidth_2;
                  uns_d     = i_LoadUnsigned_1;
                  is_load_d = i_Load_1;
                  we_d      = ~i_Load_1;
                  wstrb_d   = strb_new;
                  wdata_d   = wdata_new;
                  cnt_d     = '0;
               end
            end
         end
         REQ: begin
            stall = 1'b1;
            // Ack takes priority over a timeout landing in the same cycle.
            if (bus.i_MemAck_1) begin
               state_d = DONE;
               if (is_load_q) begin
                  load_data_d = load_ext;
               end
            end else if ((TIMEOUT_CYCLES != 0) && (cnt_inc == TIMEOUT_VAL)) begin
               state_d   = IDLE;
               bus_err_d = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         DONE:    state_d = IDLE;
         FAULT:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         off_q       <= '0;
         width_q     <= '0;
         uns_q       <= 1'b0;
         is_load_q   <= 1'b0;
         we_q        <= 1'b0;
         wstrb_q     <= '0;
         wdata_q     <= '0;
         cnt_q       <= '0;
         load_data_q <= '0;
         bus_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         off_q       <= off_d;
         width_q     <= width_d;
         uns_q       <= uns_d;
         is_load_q   <= is_load_d;
         we_q        <= we_d;
         wstrb_q     <= wstrb_d;
         wdata_q     <= wdata_d;
         cnt_q       <= cnt_d;
         load_data_q <= load_data_d;
         bus_err_q   <= bus_err_d;
      end
   end

   assign o_Stall_1         = stall;
   assign o_LoadData_32     = load_data_q;
   assign o_LoadDataValid_1 = (state_q == DONE) & is_load_q;
   assign o_MisalignExc_1   = (state_q == FAULT);
   assign o_BusErr_1        = bus_err_q;

   assign bus.o_MemReq_1    = (state_q == REQ);
   assign bus.o_MemWe_1     = we_q;
   assign bus.o_MemAddr_32  = addr_q;
   assign bus.o_MemWstrb_4  = wstrb_q;
   assign bus.o_MemWdata_32 = wdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed spec vectors plus randomized accesses
// checked against a byte-level reference model.
module tb_mem_access_unit;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_Valid_1, i_Load_1, i_Store_1, i_LoadUnsigned_1;
   logic [1:0]  i_LoadStoreWidth_2;
   logic [31:0] i_Addr_32, i_StoreData_32;
   logic        o_Stall_1, o_LoadDataValid_1, o_MisalignExc_1, o_BusErr_1;
   logic [31:0] o_LoadData_32;

   mem_access_unit_if bus();

   mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n), .i_Valid_1(i_Valid_1), .i_Load_1(i_Load_1),
      .i_Store_1(i_Store_1), .i_LoadUnsigned_1(i_LoadUnsigned_1),
      .i_LoadStoreWidth_2(i_LoadStoreWidth_2), .i_Addr_32(i_Addr_32),
      .i_StoreData_32(i_StoreData_32), .o_Stall_1(o_Stall_1), .o_LoadData_32(o_LoadData_32),
      .o_LoadDataValid_1(o_LoadDataValid_1), .o_MisalignExc_1(o_MisalignExc_1),
      .o_BusErr_1(o_BusErr_1), .bus(bus)
   );

   always #5 clk = ~clk;

   int pass_cnt = 0;
   int total_cnt = 0;

   // Observations from the most recent access
   int          obs_req, obs_valid, obs_mis, obs_err, obs_stall;
   bit          obs_idle_stall, obs_unstable, obs_valid_after, obs_err_after;
   logic [31:0] obs_addr, obs_wdata, obs_ldata, obs_final_ldata;
   logic [3:0]  obs_wstrb;
   logic        obs_we;
   logic [31:0] exp_hold;

   typedef struct {
      bit          fault;
      logic [31:0] maddr;
      logic        we;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
      logic [31:0] ldata;
   } exp_t;

   function automatic exp_t model(bit ld, bit uns, logic [1:0] w, logic [31:0] a,
                                  logic [31:0] sd, logic [31:0] rd);
      exp_t e;
      int size, off;
      longint unsigned v, span;
      off  = int'(a % 4);
      size = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
      e.fault = (w == 2'd3) || ((a % size) != 0);
      e.maddr = a - (a % 4);
      e.we    = !ld;
      e.wstrb = 4'b0000;
      e.wdata = 32'd0;
      for (int i = 0; i < 4; i++) begin
         if (!ld && i >= off && i < off + size) e.wstrb[i] = 1'b1;
         e.wdata[8*i +: 8] = sd[8*(i % size) +: 8];
      end
      span = 64'd1 << (8 * size);
      v = (longint'(rd) >> (8 * off)) % span;
      if (!uns && size < 4 && v >= span / 2) v = v + 64'h1_0000_0000 - span;
      e.ldata = v[31:0];
      return e;
   endfunction

   task automatic run_access(input bit ld, input bit st, input bit uns, input logic [1:0] w,
                             input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                             input int ack_delay);
      int last_req;
      @(negedge clk);
      i_Valid_1 = 1'b1; i_Load_1 = ld; i_Store_1 = st; i_LoadUnsigned_1 = uns;
      i_LoadStoreWidth_2 = w; i_Addr_32 = a; i_StoreData_32 = sd;
      #1 obs_idle_stall = o_Stall_1;
      obs_req = 0; obs_valid = 0; obs_mis = 0; obs_err = 0; obs_stall = 0;
      obs_unstable = 0; obs_valid_after = 0; obs_err_after = 0;
      obs_addr = '0; obs_wdata = '0; obs_wstrb = '0; obs_we = 1'b0; obs_ldata = '0;
      last_req = -10;
      for (int cyc = 0; cyc < 12; cyc++) begin
         @(negedge clk);
         if (cyc == 0) begin
            i_Valid_1 = 1'b0; i_Load_1 = 1'b0; i_Store_1 = 1'b0;
            i_Addr_32 = $urandom; i_StoreData_32 = $urandom;
         end
         bus.i_MemAck_1 = 1'b0;
         #1;
         if (bus.o_MemReq_1) begin
            obs_req++;
            if (obs_req == 1) begin
               obs_addr = bus.o_MemAddr_32; obs_we = bus.o_MemWe_1;
               obs_wstrb = bus.o_MemWstrb_4; obs_wdata = bus.o_MemWdata_32;
            end else if (obs_addr !== bus.o_MemAddr_32 || obs_we !== bus.o_MemWe_1 ||
                         obs_wstrb !== bus.o_MemWstrb_4 || obs_wdata !== bus.o_MemWdata_32) begin
               obs_unstable = 1;
            end
            last_req = cyc;
            if (ack_delay >= 0 && obs_req == ack_delay + 1) begin
               bus.i_MemAck_1 = 1'b1; bus.i_MemRdata_32 = rd;
            end else begin
               bus.i_MemRdata_32 = $urandom;
            end
         end else begin
            // Stray acks outside REQ must be ignored
            bus.i_MemAck_1 = ($urandom % 3 == 0);
            bus.i_MemRdata_32 = $urandom;
         end
         if (o_LoadDataValid_1) begin
            obs_valid++; obs_ldata = o_LoadData_32; obs_valid_after = (cyc == last_req + 1);
         end
         if (o_MisalignExc_1) obs_mis++;
         if (o_BusErr_1) begin
            obs_err++; obs_err_after = (cyc == last_req + 1);
         end
         if (o_Stall_1) obs_stall++;
      end
      bus.i_MemAck_1 = 1'b0;
      obs_final_ldata = o_LoadData_32;
      $display("access ld=%0d st=%0d uns=%0d w=%0d addr=%h sd=%h rd=%h req=%0d valid=%0d ldata=%h mis=%0d err=%0d",
               ld, st, uns, w, a, sd, rd, obs_req, obs_valid, obs_ldata, obs_mis, obs_err);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; i_Valid_1 = 0; i_Load_1 = 0; i_Store_1 = 0; i_LoadUnsigned_1 = 0;
      i_LoadStoreWidth_2 = 0; i_Addr_32 = 0; i_StoreData_32 = 0;
      bus.i_MemAck_1 = 0; bus.i_MemRdata_32 = 0;
      repeat (3) @(negedge clk);
      total_cnt++;
      if ({bus.o_MemReq_1, bus.o_MemWe_1, bus.o_MemWstrb_4} !== 6'd0)
         $display("FAIL reset_bus_ctrl: got %b expected 000000",
                  {bus.o_MemReq_1, bus.o_MemWe_1, bus.o_MemWstrb_4});
      else pass_cnt++;
      total_cnt++;
      if ({bus.o_MemAddr_32, bus.o_MemWdata_32, o_LoadData_32} !== 96'd0)
         $display("FAIL reset_data: got %h expected 0",
                  {bus.o_MemAddr_32, bus.o_MemWdata_32, o_LoadData_32});
      else pass_cnt++;
      total_cnt++;
      if ({o_Stall_1, o_LoadDataValid_1, o_MisalignExc_1, o_BusErr_1} !== 4'd0)
         $display("FAIL reset_flags: got %b expected 0000",
                  {o_Stall_1, o_LoadDataValid_1, o_MisalignExc_1, o_BusErr_1});
      else pass_cnt++;
      rst_n = 1'b1;
      exp_hold = 32'd0;
      @(negedge clk);
   endtask

   task automatic test_load_word();
      run_access(1, 0, 0, 2'b10, 32'h100, 32'h0, 32'hDEADBEEF, 2);
      total_cnt++;
      if (obs_req !== 3) $display("FAIL lw_req_cycles: got %0d expected 3", obs_req);
      else pass_cnt++;
      total_cnt++;
      if (obs_valid !== 1 || !obs_valid_after || obs_ldata !== 32'hDEADBEEF)
         $display("FAIL lw_data: got valid=%0d after=%0d data=%h expected valid=1 after=1 data=deadbeef",
                  obs_valid, obs_valid_after, obs_ldata);
      else pass_cnt++;
      total_cnt++;
      if (obs_idle_stall !== 1'b1 || obs_stall !== 3)
         $display("FAIL lw_stall: got idle=%0d req=%0d expected idle=1 req=3", obs_idle_stall, obs_stall);
      else pass_cnt++;
   endtask

   task automatic test_load_subword();
      run_access(1, 0, 0, 2'b00, 32'h203, 32'h0, 32'h80112233, 0);
      total_cnt++;
      if (obs_addr !== 32'h200 || obs_ldata !== 32'hFFFFFF80 || obs_we !== 1'b0 || obs_wstrb !== 4'd0)
         $display("FAIL lb: got addr=%h data=%h we=%0d strb=%b expected addr=200 data=ffffff80 we=0 strb=0000",
                  obs_addr, obs_ldata, obs_we, obs_wstrb);
      else pass_cnt++;
      run_access(1, 0, 1, 2'b00, 32'h203, 32'h0, 32'h80112233, 1);
      total_cnt++;
      if (obs_ldata !== 32'h00000080) $display("FAIL lbu: got %h expected 00000080", obs_ldata);
      else pass_cnt++;
      run_access(1, 0, 1, 2'b01, 32'h302, 32'h0, 32'hBEEF1234, 0);
      total_cnt++;
      if (obs_ldata !== 32'h0000BEEF) $display("FAIL lhu: got %h expected 0000beef", obs_ldata);
      else pass_cnt++;
      run_access(1, 0, 0, 2'b01, 32'h302, 32'h0, 32'hBEEF1234, 0);
      total_cnt++;
      if (obs_ldata !== 32'hFFFFBEEF || obs_final_ldata !== 32'hFFFFBEEF)
         $display("FAIL lh: got %h hold=%h expected ffffbeef", obs_ldata, obs_final_ldata);
      else pass_cnt++;
   endtask

   task automatic test_store();
      run_access(0, 1, 0, 2'b00, 32'h401, 32'h123456AB, 32'h0, 1);
      total_cnt++;
      if (obs_we !== 1'b1 || obs_wstrb !== 4'b0010 || obs_wdata !== 32'hABABABAB || obs_addr !== 32'h400)
         $display("FAIL sb_bus: got we=%0d strb=%b wdata=%h addr=%h expected we=1 strb=0010 wdata=abababab addr=400",
                  obs_we, obs_wstrb, obs_wdata, obs_addr);
      else pass_cnt++;
      total_cnt++;
      if (obs_valid !== 0 || obs_final_ldata !== 32'hFFFFBEEF)
         $display("FAIL sb_no_load: got valid=%0d hold=%h expected valid=0 hold=ffffbeef",
                  obs_valid, obs_final_ldata);
      else pass_cnt++;
      total_cnt++;
      if (obs_unstable) $display("FAIL sb_stable: got unstable=1 expected 0");
      else pass_cnt++;
   endtask

   task automatic test_misalign();
      run_access(1, 0, 0, 2'b10, 32'h502, 32'h0, 32'h0, 0);
      total_cnt++;
      if (obs_mis !== 1 || obs_req !== 0 || obs_idle_stall !== 1'b1 || obs_stall !== 0)
         $display("FAIL lw_misalign: got mis=%0d req=%0d idle_stall=%0d later_stall=%0d expected 1 0 1 0",
                  obs_mis, obs_req, obs_idle_stall, obs_stall);
      else pass_cnt++;
      run_access(0, 1, 0, 2'b11, 32'h500, 32'h0, 32'h0, 0);
      total_cnt++;
      if (obs_mis !== 1 || obs_req !== 0)
         $display("FAIL width11: got mis=%0d req=%0d expected mis=1 req=0", obs_mis, obs_req);
      else pass_cnt++;
   endtask

   task automatic test_timeout();
      run_access(1, 0, 0, 2'b10, 32'h600, 32'h0, 32'h0, -1);
      total_cnt++;
      if (obs_req !== 4 || obs_err !== 1 || !obs_err_after)
         $display("FAIL timeout: got req=%0d err=%0d after=%0d expected req=4 err=1 after=1",
                  obs_req, obs_err, obs_err_after);
      else pass_cnt++;
      total_cnt++;
      if (obs_valid !== 0 || obs_final_ldata !== 32'hFFFFBEEF)
         $display("FAIL timeout_no_load: got valid=%0d hold=%h expected 0 ffffbeef", obs_valid, obs_final_ldata);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [5:0] stall_v, req_v;
      int vcount;
      vcount = 0;
      @(negedge clk);
      i_Valid_1 = 1; i_Load_1 = 1; i_Store_1 = 0; i_LoadUnsigned_1 = 0;
      i_LoadStoreWidth_2 = 2'b10; i_Addr_32 = 32'h700; bus.i_MemRdata_32 = 32'h0BADF00D;
      for (int c = 0; c < 6; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         stall_v[c] = o_Stall_1;
         req_v[c] = bus.o_MemReq_1;
         if (o_LoadDataValid_1) vcount++;
         bus.i_MemAck_1 = bus.o_MemReq_1;
      end
      @(negedge clk);
      i_Valid_1 = 0; i_Load_1 = 0; bus.i_MemAck_1 = 0;
      exp_hold = 32'h0BADF00D;
      $display("back_to_back stall=%b req=%b valid_pulses=%0d", stall_v, req_v, vcount);
      total_cnt++;
      if (stall_v !== 6'b011011) $display("FAIL b2b_stall: got %b expected 011011", stall_v);
      else pass_cnt++;
      total_cnt++;
      if (req_v !== 6'b010010 || vcount !== 2)
         $display("FAIL b2b_req: got req=%b pulses=%0d expected req=010010 pulses=2", req_v, vcount);
      else pass_cnt++;
      @(negedge clk);
   endtask

   task automatic test_random();
      exp_t e;
      bit ld, st, uns;
      logic [1:0] w;
      logic [31:0] a, sd, rd;
      int dly;
      for (int n = 0; n < 40; n++) begin
         ld  = 1'($urandom % 2);
         st  = ld ? 1'($urandom % 2) : 1'b1;
         uns = 1'($urandom % 2);
         w   = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3);
         a   = $urandom;
         if ($urandom % 2 == 1) a = a - (a % ((w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4));
         sd  = $urandom; rd = $urandom;
         dly = int'($urandom % 4);
         e = model(ld, uns, w, a, sd, rd);
         run_access(ld, st, uns, w, a, sd, rd, dly);
         if (e.fault) begin
            total_cnt++;
            if (obs_mis !== 1 || obs_req !== 0 || obs_valid !== 0 || obs_stall !== 0 || obs_idle_stall !== 1'b1)
               $display("FAIL rand_fault #%0d: got mis=%0d req=%0d valid=%0d stall=%0d expected 1 0 0 0",
                        n, obs_mis, obs_req, obs_valid, obs_stall);
            else pass_cnt++;
         end else begin
            total_cnt++;
            if (obs_req !== dly + 1 || obs_mis !== 0 || obs_err !== 0 || obs_unstable || obs_stall !== dly + 1)
               $display("FAIL rand_handshake #%0d: got req=%0d mis=%0d err=%0d unstable=%0d stall=%0d expected req=%0d",
                        n, obs_req, obs_mis, obs_err, obs_unstable, obs_stall, dly + 1);
            else pass_cnt++;
            total_cnt++;
            if ({obs_addr, obs_we, obs_wstrb} !== {e.maddr, e.we, e.wstrb})
               $display("FAIL rand_bus #%0d: got addr=%h we=%0d strb=%b expected addr=%h we=%0d strb=%b",
                        n, obs_addr, obs_we, obs_wstrb, e.maddr, e.we, e.wstrb);
            else pass_cnt++;
            if (ld) begin
               exp_hold = e.ldata;
               total_cnt++;
               if (obs_valid !== 1 || !obs_valid_after || obs_ldata !== e.ldata)
                  $display("FAIL rand_load #%0d: got valid=%0d after=%0d data=%h expected 1 1 %h",
                           n, obs_valid, obs_valid_after, obs_ldata, e.ldata);
               else pass_cnt++;
            end else begin
               total_cnt++;
               if (obs_wdata !== e.wdata || obs_valid !== 0)
                  $display("FAIL rand_store #%0d: got wdata=%h valid=%0d expected %h 0",
                           n, obs_wdata, obs_valid, e.wdata);
               else pass_cnt++;
            end
         end
         total_cnt++;
         if (obs_final_ldata !== exp_hold)
            $display("FAIL rand_hold #%0d: got %h expected %h", n, obs_final_ldata, exp_hold);
         else pass_cnt++;
      end
   endtask

   task automatic test_reset_mid();
      int pulses;
      pulses = 0;
      @(negedge clk);
      i_Valid_1 = 1; i_Load_1 = 0; i_Store_1 = 1; i_LoadStoreWidth_2 = 2'b10;
      i_Addr_32 = 32'h800; i_StoreData_32 = 32'hCAFEF00D;
      @(negedge clk);
      i_Valid_1 = 0; i_Store_1 = 0;
      #1;
      total_cnt++;
      if (bus.o_MemReq_1 !== 1'b1) $display("FAIL rst_mid_setup: got req=%0d expected 1", bus.o_MemReq_1);
      else pass_cnt++;
      #2 rst_n = 1'b0;
      #1;
      $display("reset_mid req=%0d we=%0d addr=%h ldata=%h", bus.o_MemReq_1, bus.o_MemWe_1,
               bus.o_MemAddr_32, o_LoadData_32);
      total_cnt++;
      if ({bus.o_MemReq_1, bus.o_MemWe_1, bus.o_MemWstrb_4, bus.o_MemAddr_32, bus.o_MemWdata_32,
           o_LoadData_32, o_Stall_1, o_LoadDataValid_1, o_MisalignExc_1, o_BusErr_1} !== 106'd0)
         $display("FAIL rst_mid_outputs: got req=%0d we=%0d addr=%h wdata=%h ldata=%h expected all 0",
                  bus.o_MemReq_1, bus.o_MemWe_1, bus.o_MemAddr_32, bus.o_MemWdata_32, o_LoadData_32);
      else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         bus.i_MemAck_1 = 1'b1;
         if (o_LoadDataValid_1 | o_MisalignExc_1 | o_BusErr_1 | bus.o_MemReq_1) pulses++;
      end
      bus.i_MemAck_1 = 1'b0;
      total_cnt++;
      if (pulses !== 0) $display("FAIL rst_mid_quiet: got %0d active cycles expected 0", pulses);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_load_word();
      test_load_subword();
      test_store();
      test_misalign();
      test_timeout();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
